// File: rtl/ndma_burst_write_mgr.sv
// NanoDMA burst write manager: turns one command into a pipelined train of OBI writes,
// bounding granted-but-unanswered transactions and reporting completion with a sticky error.
module ndma_burst_write_mgr #(
    parameter int unsigned DW              = 32,
    parameter int unsigned AW              = 32,
    parameter int unsigned LEN_W           = 16,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic [AW-1:0]   cmd_addr_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic            cmd_incr_i,

    input  logic            wdata_valid_i,
    output logic            wdata_ready_o,
    input  logic [DW-1:0]   wdata_i,

    output logic            obi_req_o,
    input  logic            obi_gnt_i,
    output logic [AW-1:0]   obi_addr_o,
    output logic            obi_we_o,
    output logic [DW/8-1:0] obi_be_o,
    output logic [DW-1:0]   obi_wdata_o,
    input  logic            obi_rvalid_i,
    input  logic            obi_err_i,

    output logic            busy_o,
    output logic            done_o,
    output logic            err_o
);

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0]    MaxOut  = OW'(MAX_OUTSTANDING);
    localparam logic [AW-1:0]    Step    = AW'(DW / 8);
    localparam logic [LEN_W-1:0] LenOne  = LEN_W'(1);
    localparam logic [OW-1:0]    OutOne  = OW'(1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             incr_q, incr_d;
    logic [OW-1:0]    outst_q, outst_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic can_issue;
    logic fire;
    logic rsp;

    // The outstanding limit gates the request; rvalid deliberately does not feed it.
    assign can_issue = (state_q == StIssue) && wdata_valid_i && (outst_q < MaxOut);
    assign fire      = can_issue && obi_gnt_i;
    assign rsp       = obi_rvalid_i && (outst_q != '0);

    always_comb begin
        outst_d = outst_q;
        if (fire && !rsp) begin
            outst_d = outst_q + OutOne;
        end else if (!fire && rsp) begin
            outst_d = outst_q - OutOne;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        incr_d        = incr_q;
        err_d         = err_q;
        done_d        = 1'b0;
        cmd_ready_o   = 1'b0;
        obi_req_o     = 1'b0;
        wdata_ready_o = 1'b0;

        if (rsp && obi_err_i) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    addr_d = cmd_addr_i;
                    rem_d  = cmd_len_i;
                    incr_d = cmd_incr_i;
                    err_d  = 1'b0;
                    if (cmd_len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                obi_req_o     = can_issue;
                wdata_ready_o = fire;
                if (fire) begin
                    rem_d = rem_q - LenOne;
                    if (incr_q) begin
                        addr_d = addr_q + Step;
                    end
                    if (rem_q == LenOne) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (outst_d == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rem_q   <= '0;
            incr_q  <= 1'b0;
            outst_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            incr_q  <= incr_d;
            outst_q <= outst_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign obi_addr_o  = addr_q;
    assign obi_we_o    = 1'b1;
    assign obi_be_o    = '1;
    assign obi_wdata_o = wdata_i;
    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;
    // The sticky error is only meaningful alongside the completion pulse.
    assign err_o       = done_q & err_q;

endmodule
